// File: rtl/seq_magnitude_comparator_pkg.sv
// ---------------------------------------------------------------------------
// comparator_pkg
// Shared definitions for seq_magnitude_comparator:
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - idx_width(): width of the slice index counter, ceil(log2(nslice+1)),
//     never less than 1 bit.
// ---------------------------------------------------------------------------
package comparator_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Smallest width w such that 2**w >= nslice+1, so the counter can hold
  // every value 0..nslice without wrapping.
  function automatic int idx_width(input int nslice);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < (nslice + 32'sd1)) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_slice_subtractor.sv
// ---------------------------------------------------------------------------
// slice_subtractor
// Combinational SLICE-bit ripple-borrow subtractor: {bout, d} = x - y - bin.
// Ports:
//   x, y  in  SLICE  minuend / subtrahend slice
//   bin   in  1      borrow in
//   d     out SLICE  difference slice
//   bout  out 1      borrow out (1 when x < y + bin)
// ---------------------------------------------------------------------------
module slice_subtractor #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  // Bit-serial ripple of the borrow from LSB to MSB.
  always_comb begin
    logic br_s;
    d    = '0;
    br_s = bin;
    for (int i = 0; i < SLICE; i++) begin
      d[i] = x[i] ^ y[i] ^ br_s;
      // Borrow when x<y, or when x==y and a borrow is already pending.
      br_s = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br_s);
    end
    bout = br_s;
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
// Multi-cycle unsigned magnitude comparator (e.g. credit A vs price B).
// A-B is computed one SLICE-bit chunk per cycle, LSB chunk first, with the
// borrow carried between chunks; the result is offered on a valid/ready
// handshake. Latency: res_valid rises NSLICE+1 edges after the accept edge
// (counting the accept edge).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        request; accepted only while in_ready=1
//   a, b         operands, sampled on accept
//   in_ready     high only in IDLE
//   res_valid    result valid, held until res_ready
//   res_ready    consumer accepts result
//   a_gte_b      A >= B
//   a_eq_b       A == B
//   diff         A-B mod 2**WIDTH (only when CHANGE_OUT_EN is defined)
// Configuration macro: CHANGE_OUT_EN enables the diff port and register.
// ---------------------------------------------------------------------------
module seq_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             a_gte_b,
  output logic             a_eq_b
`ifdef CHANGE_OUT_EN
  ,
  output logic [WIDTH-1:0] diff
`endif
);

  localparam int             NSLICE   = WIDTH / SLICE;
  localparam int             IDXW     = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             nz_q, nz_d;
  logic             gte_q, gte_d;
  logic             eq_q, eq_d;
  logic [SLICE-1:0] d_s;
  logic             bout_s;
  logic             nz_next_s;
`ifdef CHANGE_OUT_EN
  logic [WIDTH-1:0]       diff_q, diff_d;
  logic [WIDTH+SLICE-1:0] diff_cat_s;
`endif

  // The operand registers shift right each BUSY cycle, so the active slice
  // is always the low SLICE bits.
  slice_subtractor #(.SLICE(SLICE)) u_sub (
    .x    (a_q[SLICE-1:0]),
    .y    (b_q[SLICE-1:0]),
    .bin  (borrow_q),
    .d    (d_s),
    .bout (bout_s)
  );

  // FSM state register plus the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = BUSY;
        else       state_d = IDLE;
      end
      BUSY: begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   state_d = BUSY;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they are registered in step
  // with the state itself.
  always_comb begin
    in_ready_d  = 1'b0;
    res_valid_d = 1'b0;
    case (state_d)
      IDLE:    in_ready_d  = 1'b1;
      DONE:    res_valid_d = 1'b1;
      default: begin
        in_ready_d  = 1'b0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  assign nz_next_s = nz_q | (d_s != {SLICE{1'b0}});

  // Datapath next-state: operand capture on accept, one slice per BUSY cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    nz_d     = nz_q;
    gte_d    = gte_q;
    eq_d     = eq_q;
`ifdef CHANGE_OUT_EN
    diff_cat_s = {d_s, diff_q} >> SLICE;
    diff_d     = diff_q;
`endif
    if (state_q == IDLE && start) begin
      a_d      = a;
      b_d      = b;
      idx_d    = '0;
      borrow_d = 1'b0;
      nz_d     = 1'b0;
    end else if (state_q == BUSY) begin
      a_d      = a_q >> SLICE;
      b_d      = b_q >> SLICE;
      idx_d    = idx_q + IDXW'(1);
      borrow_d = bout_s;
      nz_d     = nz_next_s;
`ifdef CHANGE_OUT_EN
      // Each new slice enters at the top; after NSLICE shifts slice 0 sits
      // at the bottom.
      diff_d = diff_cat_s[WIDTH-1:0];
`endif
      // Flags are captured on the final slice so they are stable in DONE.
      if (idx_q == LAST_IDX) begin
        gte_d = ~bout_s;
        eq_d  = ~bout_s & ~nz_next_s;
      end else begin
        gte_d = gte_q;
        eq_d  = eq_q;
      end
    end else begin
      a_d = a_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      nz_q     <= 1'b0;
      gte_q    <= 1'b0;
      eq_q     <= 1'b0;
`ifdef CHANGE_OUT_EN
      diff_q   <= '0;
`endif
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      nz_q     <= nz_d;
      gte_q    <= gte_d;
      eq_q     <= eq_d;
`ifdef CHANGE_OUT_EN
      diff_q   <= diff_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign a_gte_b   = gte_q;
  assign a_eq_b    = eq_q;
`ifdef CHANGE_OUT_EN
  assign diff      = diff_q;
`endif

endmodule
